riscv_bus_arbiter: RTL and testbench

RISCV_BUS_ARBITER -- requirements
Module: riscv_bus_arbiter

---
 rtl/riscv_bus_arbiter_if.sv | 49 ++++
 rtl/riscv_bus_arbiter.sv | 100 ++++++++++
 tb/tb_riscv_bus_arbiter.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/riscv_bus_arbiter_if.sv
// Signal bundle between the fetch port, the M-stage data port, the shared bus and the arbiter.
// The arbiter connects through the master modport; the surrounding fabric uses slave.
interface riscv_bus_arbiter_if;
  logic        i_if_req;
  logic [31:0] i_if_addr;
  logic [31:0] o_if_rdata;
  logic        o_if_rvalid;

  logic        i_dm_req;
  logic        i_dm_we;
  logic [3:0]  i_dm_be;
  logic [31:0] i_dm_addr;
  logic [31:0] i_dm_wdata;
  logic [31:0] o_dm_rdata;
  logic        o_dm_rvalid;

  logic        o_bus_req;
  logic        o_bus_we;
  logic [3:0]  o_bus_be;
  logic [31:0] o_bus_addr;
  logic [31:0] o_bus_wdata;
  logic        i_bus_gnt;
  logic        i_bus_rvalid;
  logic [31:0] i_bus_rdata;

  logic        o_bus_stallM;
  logic        o_if_stall;
  logic        o_bus_err;

  modport master (
    input  i_if_req, i_if_addr,
    output o_if_rdata, o_if_rvalid,
    input  i_dm_req, i_dm_we, i_dm_be, i_dm_addr, i_dm_wdata,
    output o_dm_rdata, o_dm_rvalid,
    output o_bus_req, o_bus_we, o_bus_be, o_bus_addr, o_bus_wdata,
    input  i_bus_gnt, i_bus_rvalid, i_bus_rdata,
    output o_bus_stallM, o_if_stall, o_bus_err
  );

  modport slave (
    output i_if_req, i_if_addr,
    input  o_if_rdata, o_if_rvalid,
    output i_dm_req, i_dm_we, i_dm_be, i_dm_addr, i_dm_wdata,
    input  o_dm_rdata, o_dm_rvalid,
    input  o_bus_req, o_bus_we, o_bus_be, o_bus_addr, o_bus_wdata,
    output i_bus_gnt, i_bus_rvalid, i_bus_rdata,
    input  o_bus_stallM, o_if_stall, o_bus_err
  );
endinterface

// File: rtl/riscv_bus_arbiter.sv
// Two-port (fetch / data) arbiter onto a single shared bus, one outstanding access at a time.
// Data port has priority, with a streak limit so fetch cannot starve; 256-cycle access timeout.
module riscv_bus_arbiter (
  input  logic                 clk,
  input  logic                 rst_n,
  riscv_bus_arbiter_if.master  bus
);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  state_t      state;
  logic        owner_dm;
  logic [1:0]  streak;
  logic [7:0]  timer;
  logic        lat_we;
  logic [3:0]  lat_be;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;

  logic dm_win;
  logic if_win;
  logic in_req;
  logic active;
  logic done;
  logic timeout;

  always_comb begin
    dm_win  = bus.i_dm_req & ~(bus.i_if_req & (streak == 2'd3));
    if_win  = bus.i_if_req & ~dm_win;
    in_req  = (state == REQ);
    active  = (state == REQ) || (state == RESP);
    done    = (in_req & bus.i_bus_gnt & bus.i_bus_rvalid) |
              ((state == RESP) & bus.i_bus_rvalid);
    // A real completion in the last timer cycle takes precedence over the timeout.
    timeout = active & ~done & (timer == 8'hFF);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      owner_dm  <= 1'b0;
      streak    <= 2'd0;
      timer     <= 8'd0;
      lat_we    <= 1'b0;
      lat_be    <= 4'h0;
      lat_addr  <= 32'h0;
      lat_wdata <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          timer <= 8'd0;
          if (dm_win) begin
            owner_dm  <= 1'b1;
            lat_we    <= bus.i_dm_we;
            lat_be    <= bus.i_dm_be;
            lat_addr  <= bus.i_dm_addr;
            lat_wdata <= bus.i_dm_wdata;
            if (bus.i_if_req && (streak != 2'd3))
              streak <= streak + 2'd1;
            state <= REQ;
          end else if (if_win) begin
            owner_dm  <= 1'b0;
            lat_we    <= 1'b0;
            lat_be    <= 4'hF;
            lat_addr  <= bus.i_if_addr;
            lat_wdata <= 32'h0;
            streak    <= 2'd0;
            state     <= REQ;
          end
        end
        REQ, RESP: begin
          timer <= timer + 8'd1;
          if (done || timeout)
            state <= IDLE;
          else if (in_req && bus.i_bus_gnt)
            state <= RESP;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    bus.o_bus_req   = in_req;
    bus.o_bus_we    = in_req ? lat_we    : 1'b0;
    bus.o_bus_be    = in_req ? lat_be    : 4'h0;
    bus.o_bus_addr  = in_req ? lat_addr  : 32'h0;
    bus.o_bus_wdata = in_req ? lat_wdata : 32'h0;

    bus.o_dm_rvalid = owner_dm & (done | timeout);
    bus.o_if_rvalid = ~owner_dm & (done | timeout);
    bus.o_dm_rdata  = (owner_dm & done)  ? bus.i_bus_rdata : 32'h0;
    bus.o_if_rdata  = (~owner_dm & done) ? bus.i_bus_rdata : 32'h0;
    bus.o_bus_err   = timeout;

    bus.o_bus_stallM = bus.i_dm_req & ~bus.o_dm_rvalid;
    bus.o_if_stall   = bus.i_if_req & ~bus.o_if_rvalid;
  end

endmodule

// File: tb/tb_riscv_bus_arbiter.sv
// Bench for riscv_bus_arbiter: directed scenarios plus randomized traffic against a
// transaction-level model of grant order, bus payload, latency and completion.
module tb_riscv_bus_arbiter;

  typedef logic [138:0] vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  riscv_bus_arbiter_if ifc ();

  riscv_bus_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, act=running req=finished");
    $fatal(1, "watchdog");
  end

  function automatic vec_t snap();
    return {ifc.o_bus_req, ifc.o_bus_we, ifc.o_bus_be, ifc.o_bus_addr, ifc.o_bus_wdata,
            ifc.o_if_rvalid, ifc.o_if_rdata, ifc.o_dm_rvalid, ifc.o_dm_rdata,
            ifc.o_bus_err, ifc.o_bus_stallM, ifc.o_if_stall};
  endfunction

  function automatic vec_t mk(input logic req, input logic we, input logic [3:0] be,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic ifv, input logic [31:0] ifd,
                              input logic dmv, input logic [31:0] dmd,
                              input logic err, input logic sm, input logic si);
    return {req, we, be, addr, wdata, ifv, ifd, dmv, dmd, err, sm, si};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic zero_inputs();
    ifc.i_if_req     = 1'b0;
    ifc.i_if_addr    = 32'h0;
    ifc.i_dm_req     = 1'b0;
    ifc.i_dm_we      = 1'b0;
    ifc.i_dm_be      = 4'h0;
    ifc.i_dm_addr    = 32'h0;
    ifc.i_dm_wdata   = 32'h0;
    ifc.i_bus_gnt    = 1'b0;
    ifc.i_bus_rvalid = 1'b0;
    ifc.i_bus_rdata  = 32'h0;
  endtask

  task automatic do_reset();
    zero_inputs();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    vec_t exp;
    zero_inputs();
    rst_n = 1'b0;
    ifc.i_dm_req = 1'b1;
    ifc.i_if_req = 1'b1;
    ifc.i_bus_gnt = 1'b1;
    ifc.i_bus_rvalid = 1'b1;
    ifc.i_bus_rdata = 32'hFFFF_FFFF;
    for (int k = 0; k < 3; k++) begin
      tick();
      #2;
      exp = mk(0, 0, 4'h0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
      n_vec++;
      if (snap() !== exp) begin
        n_err++;
        $display("FAIL reset k=%0d act=%h exp=%h", k, snap(), exp);
      end
    end
    zero_inputs();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_dm_write();
    vec_t exp;
    zero_inputs();
    ifc.i_dm_req   = 1'b1;
    ifc.i_dm_we    = 1'b1;
    ifc.i_dm_be    = 4'hF;
    ifc.i_dm_addr  = 32'h100;
    ifc.i_dm_wdata = 32'hDEAD_BEEF;
    #2;
    exp = mk(0, 0, 4'h0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    n_vec++;
    if (snap() !== exp) begin n_err++; $display("FAIL dm_write_N act=%h exp=%h", snap(), exp); end
    tick();
    ifc.i_bus_gnt    = 1'b1;
    ifc.i_bus_rvalid = 1'b1;
    ifc.i_bus_rdata  = 32'h0BAD_F00D;
    #2;
    exp = mk(1, 1, 4'hF, 32'h100, 32'hDEAD_BEEF, 0, 0, 1, 32'h0BAD_F00D, 0, 0, 0);
    n_vec++;
    if (snap() !== exp) begin n_err++; $display("FAIL dm_write_N1 act=%h exp=%h", snap(), exp); end
    tick();
    zero_inputs();
    #2;
    exp = mk(0, 0, 4'h0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    n_vec++;
    if (snap() !== exp) begin n_err++; $display("FAIL dm_write_N2 act=%h exp=%h", snap(), exp); end
    tick();
  endtask

  task automatic test_fairness();
    logic exp_dm [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    vec_t exp;
    logic [31:0] rd;
    do_reset();
    ifc.i_if_req   = 1'b1;
    ifc.i_if_addr  = 32'h40;
    ifc.i_dm_req   = 1'b1;
    ifc.i_dm_we    = 1'b0;
    ifc.i_dm_be    = 4'h3;
    ifc.i_dm_addr  = 32'h200;
    ifc.i_dm_wdata = 32'h55;
    for (int k = 0; k < 8; k++) begin
      ifc.i_bus_gnt    = 1'b0;
      ifc.i_bus_rvalid = 1'b0;
      #2;
      exp = mk(0, 0, 4'h0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
      n_vec++;
      if (snap() !== exp) begin n_err++; $display("FAIL fair_idle k=%0d act=%h exp=%h", k, snap(), exp); end
      tick();
      rd = 32'h1000 + k;
      ifc.i_bus_gnt    = 1'b1;
      ifc.i_bus_rvalid = 1'b1;
      ifc.i_bus_rdata  = rd;
      #2;
      if (exp_dm[k])
        exp = mk(1, 0, 4'h3, 32'h200, 32'h55, 0, 0, 1, rd, 0, 0, 1);
      else
        exp = mk(1, 0, 4'hF, 32'h40, 32'h0, 1, rd, 0, 0, 0, 1, 0);
      n_vec++;
      if (snap() !== exp) begin n_err++; $display("FAIL fair_grant k=%0d act=%h exp=%h", k, snap(), exp); end
      tick();
    end
    zero_inputs();
    tick();
  endtask

  task automatic test_if_delayed();
    vec_t exp;
    zero_inputs();
    ifc.i_if_req  = 1'b1;
    ifc.i_if_addr = 32'h0;
    #2;
    exp = mk(0, 0, 4'h0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    n_vec++;
    if (snap() !== exp) begin n_err++; $display("FAIL ifdly_idle act=%h exp=%h", snap(), exp); end
    tick();
    for (int k = 0; k < 4; k++) begin
      ifc.i_if_addr   = $urandom;
      ifc.i_bus_gnt   = (k == 3);
      ifc.i_bus_rdata = $urandom;
      #2;
      exp = mk(1, 0, 4'hF, 32'h0, 32'h0, 0, 0, 0, 0, 0, 0, 1);
      n_vec++;
      if (snap() !== exp) begin n_err++; $display("FAIL ifdly_req k=%0d act=%h exp=%h", k, snap(), exp); end
      tick();
    end
    ifc.i_bus_gnt = 1'b0;
    #2;
    exp = mk(0, 0, 4'h0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    n_vec++;
    if (snap() !== exp) begin n_err++; $display("FAIL ifdly_resp act=%h exp=%h", snap(), exp); end
    tick();
    ifc.i_bus_rvalid = 1'b1;
    ifc.i_bus_rdata  = 32'h0000_0013;
    #2;
    exp = mk(0, 0, 4'h0, 0, 0, 1, 32'h13, 0, 0, 0, 0, 0);
    n_vec++;
    if (snap() !== exp) begin n_err++; $display("FAIL ifdly_done act=%h exp=%h", snap(), exp); end
    tick();
    zero_inputs();
    tick();
  endtask

  task automatic test_timeout();
    vec_t exp;
    zero_inputs();
    ifc.i_dm_req   = 1'b1;
    ifc.i_dm_be    = 4'hF;
    ifc.i_dm_addr  = 32'h300;
    ifc.i_dm_wdata = 32'hAAAA_5555;
    tick();
    for (int k = 1; k <= 256; k++) begin
      ifc.i_bus_rdata = $urandom | 32'h1;
      #2;
      if (k < 256)
        exp = mk(1, 0, 4'hF, 32'h300, 32'hAAAA_5555, 0, 0, 0, 0, 0, 1, 0);
      else
        exp = mk(1, 0, 4'hF, 32'h300, 32'hAAAA_5555, 0, 0, 1, 0, 1, 0, 0);
      n_vec++;
      if (snap() !== exp) begin n_err++; $display("FAIL timeout k=%0d act=%h exp=%h", k, snap(), exp); end
      tick();
    end
    ifc.i_dm_req = 1'b0;
    #2;
    exp = mk(0, 0, 4'h0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    n_vec++;
    if (snap() !== exp) begin n_err++; $display("FAIL timeout_after act=%h exp=%h", snap(), exp); end
    tick();
  endtask

  task automatic test_reset_mid();
    vec_t exp;
    zero_inputs();
    ifc.i_dm_req  = 1'b1;
    ifc.i_dm_be   = 4'hF;
    ifc.i_dm_addr = 32'h400;
    tick();
    ifc.i_bus_gnt = 1'b1;
    #2;
    exp = mk(1, 0, 4'hF, 32'h400, 0, 0, 0, 0, 0, 0, 1, 0);
    n_vec++;
    if (snap() !== exp) begin n_err++; $display("FAIL rstmid_req act=%h exp=%h", snap(), exp); end
    tick();
    ifc.i_bus_gnt = 1'b0;
    #2;
    exp = mk(0, 0, 4'h0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    n_vec++;
    if (snap() !== exp) begin n_err++; $display("FAIL rstmid_resp act=%h exp=%h", snap(), exp); end
    rst_n = 1'b0;
    ifc.i_bus_rvalid = 1'b1;
    ifc.i_bus_rdata  = 32'h1234_5678;
    #1;
    exp = mk(0, 0, 4'h0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    n_vec++;
    if (snap() !== exp) begin n_err++; $display("FAIL rstmid_assert act=%h exp=%h", snap(), exp); end
    tick();
    rst_n = 1'b1;
    ifc.i_dm_req = 1'b0;
    for (int k = 0; k < 2; k++) begin
      #2;
      exp = mk(0, 0, 4'h0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      n_vec++;
      if (snap() !== exp) begin n_err++; $display("FAIL rstmid_release k=%0d act=%h exp=%h", k, snap(), exp); end
      tick();
    end
    ifc.i_bus_rvalid = 1'b0;
    ifc.i_dm_req   = 1'b1;
    ifc.i_dm_we    = 1'b1;
    ifc.i_dm_be    = 4'h5;
    ifc.i_dm_addr  = 32'h500;
    ifc.i_dm_wdata = 32'hCAFE_0001;
    tick();
    ifc.i_bus_gnt    = 1'b1;
    ifc.i_bus_rvalid = 1'b1;
    ifc.i_bus_rdata  = 32'h0000_0042;
    #2;
    exp = mk(1, 1, 4'h5, 32'h500, 32'hCAFE_0001, 0, 0, 1, 32'h42, 0, 0, 0);
    n_vec++;
    if (snap() !== exp) begin n_err++; $display("FAIL rstmid_fresh act=%h exp=%h", snap(), exp); end
    tick();
    zero_inputs();
    tick();
  endtask

  task automatic test_spurious();
    vec_t exp;
    zero_inputs();
    ifc.i_bus_rvalid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      ifc.i_bus_rdata = $urandom;
      #2;
      exp = mk(0, 0, 4'h0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      n_vec++;
      if (snap() !== exp) begin n_err++; $display("FAIL spurious k=%0d act=%h exp=%h", k, snap(), exp); end
      tick();
    end
    ifc.i_if_req  = 1'b1;
    ifc.i_if_addr = 32'h80;
    #2;
    exp = mk(0, 0, 4'h0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    n_vec++;
    if (snap() !== exp) begin n_err++; $display("FAIL spurious_N act=%h exp=%h", snap(), exp); end
    tick();
    ifc.i_bus_gnt   = 1'b1;
    ifc.i_bus_rdata = 32'h77;
    #2;
    exp = mk(1, 0, 4'hF, 32'h80, 0, 1, 32'h77, 0, 0, 0, 0, 0);
    n_vec++;
    if (snap() !== exp) begin n_err++; $display("FAIL spurious_N1 act=%h exp=%h", snap(), exp); end
    tick();
    zero_inputs();
    tick();
  endtask

  task automatic test_random_traffic(input int n_txn);
    logic        if_pend, dm_pend, dm_w, w_dm, w_we, e_req, e_done;
    logic [3:0]  dm_b, w_be;
    logic [31:0] if_a, dm_a, dm_d, w_addr, w_wdata, rd;
    int          run, gdly, rdly, last;
    vec_t        exp;
    do_reset();
    if_pend = 1'b0; dm_pend = 1'b0; run = 0;
    if_a = 0; dm_a = 0; dm_d = 0; dm_w = 0; dm_b = 0;
    for (int t = 0; t < n_txn; t++) begin
      if (!if_pend && ($urandom_range(1, 0) == 1)) begin
        if_pend = 1'b1;
        if_a    = $urandom;
      end
      if (!dm_pend && (($urandom_range(1, 0) == 1) || !if_pend)) begin
        dm_pend = 1'b1;
        dm_a    = $urandom;
        dm_d    = $urandom;
        dm_w    = 1'($urandom_range(1, 0));
        dm_b    = 4'($urandom_range(15, 0));
      end
      // Data wins unless fetch has already waited behind three data grants in a row.
      w_dm = dm_pend && !(if_pend && run >= 3);
      if (w_dm) begin
        if (if_pend) run = run + 1;
        w_we = dm_w; w_be = dm_b; w_addr = dm_a; w_wdata = dm_d;
      end else begin
        run = 0;
        w_we = 1'b0; w_be = 4'hF; w_addr = if_a; w_wdata = 32'h0;
      end
      gdly = $urandom_range(3, 0);
      rdly = $urandom_range(2, 0);
      last = gdly + 1 + rdly;
      rd   = $urandom;
      for (int c = 0; c <= last; c++) begin
        ifc.i_if_req = if_pend;
        ifc.i_dm_req = dm_pend;
        if (c == 0) begin
          ifc.i_if_addr    = if_a;
          ifc.i_dm_we      = dm_w;
          ifc.i_dm_be      = dm_b;
          ifc.i_dm_addr    = dm_a;
          ifc.i_dm_wdata   = dm_d;
          ifc.i_bus_gnt    = 1'b0;
          ifc.i_bus_rvalid = 1'($urandom_range(1, 0));
          ifc.i_bus_rdata  = $urandom;
        end else begin
          if (w_dm) begin
            ifc.i_dm_we    = 1'($urandom_range(1, 0));
            ifc.i_dm_be    = 4'($urandom_range(15, 0));
            ifc.i_dm_addr  = $urandom;
            ifc.i_dm_wdata = $urandom;
          end else begin
            ifc.i_if_addr  = $urandom;
          end
          ifc.i_bus_gnt    = (c == gdly + 1) ? 1'b1 :
                             (c > gdly + 1) ? 1'($urandom_range(1, 0)) : 1'b0;
          ifc.i_bus_rvalid = (c == last);
          ifc.i_bus_rdata  = (c == last) ? rd : $urandom;
        end
        e_req  = (c >= 1) && (c <= gdly + 1);
        e_done = (c == last);
        exp = mk(e_req, e_req & w_we, e_req ? w_be : 4'h0,
                 e_req ? w_addr : 32'h0, e_req ? w_wdata : 32'h0,
                 e_done & !w_dm, (e_done & !w_dm) ? rd : 32'h0,
                 e_done & w_dm, (e_done & w_dm) ? rd : 32'h0,
                 1'b0, dm_pend & !(e_done & w_dm), if_pend & !(e_done & !w_dm));
        #2;
        n_vec++;
        if (snap() !== exp) begin
          n_err++;
          $display("FAIL random t=%0d c=%0d act=%h exp=%h", t, c, snap(), exp);
        end
        tick();
      end
      if (w_dm) dm_pend = 1'b0;
      else      if_pend = 1'b0;
    end
    zero_inputs();
    tick();
  endtask

  initial begin
    zero_inputs();
    test_reset();
    test_dm_write();
    test_fairness();
    test_if_delayed();
    test_timeout();
    test_reset_mid();
    test_spurious();
    test_random_traffic(150);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
